// File: rtl/clb_cfg_pkg.sv
// Shared constants, config-word field layout and loader state encoding
// for the CLB configuration loader.
package clb_cfg_pkg;

  localparam int         CFG_W     = 37;
  localparam int         LEN_W     = 16;
  localparam int         BIT_CNT_W = 6;
  localparam logic [3:0] PREAMBLE  = 4'b0010;

  // Field offsets into the configuration word (bit 0 = floporlatch)
  localparam int MEM_OFF  = 21;
  localparam int MEM_W    = 16;
  localparam int COMB_OFF = 19;
  localparam int COMB_W   = 2;
  localparam int MUX2_OFF = 17;
  localparam int MUX3_OFF = 15;
  localparam int MUX4_OFF = 13;
  localparam int MUX5_OFF = 11;
  localparam int MUX6_OFF = 9;
  localparam int MUX_W    = 2;
  localparam int O2M_OFF  = 3;
  localparam int O2M_W    = 6;
  localparam int DQ_OFF   = 1;
  localparam int DQ_W     = 2;
  localparam int FL_OFF   = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_DONE,
    ST_ERR
  } cfg_state_e;

endpackage

// File: rtl/clb_cfg_shreg.sv
// Enable-gated MSB-first serial-in/parallel-out shift register.
module clb_cfg_shreg #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              en,
  input  logic              din,
  output logic [DATA_W-1:0] q
);

  always_ff @(posedge clk) begin
    if (en) q <= {q[DATA_W-2:0], din};
  end

endmodule

// File: rtl/clb_cfg_loader.sv
// Serial CLB configuration loader: parses preamble, length and framed words,
// and emits one addressed configuration write per CLB, then DONE or ERR.
module clb_cfg_loader
  import clb_cfg_pkg::*;
#(
  parameter int NUM_CLB = 64,
  parameter int ADDR_W  = 6
) (
  input  logic              K,
  input  logic              RST,
  input  logic              DIN,
  input  logic              DIN_VALID,
  output logic [CFG_W-1:0]  CFG_DATA,
  output logic [ADDR_W-1:0] CFG_ADDR,
  output logic              CFG_WE,
  output logic              DONE,
  output logic              ERR
);

  localparam logic [LEN_W-1:0]     MAX_LEN   = LEN_W'(NUM_CLB);
  localparam logic [LEN_W-1:0]     LEN_ONE   = LEN_W'(1);
  localparam logic [BIT_CNT_W-1:0] LEN_LAST  = BIT_CNT_W'(LEN_W - 1);
  localparam logic [BIT_CNT_W-1:0] DATA_LAST = BIT_CNT_W'(CFG_W - 1);
  localparam logic [BIT_CNT_W-1:0] CNT_ONE   = BIT_CNT_W'(1);
  localparam logic [ADDR_W:0]      FRM_ONE   = (ADDR_W + 1)'(1);

  cfg_state_e           state_q, state_d;
  logic [3:0]           hist_q, hist_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q;
  logic [ADDR_W:0]      frame_cnt_q;
  logic [LEN_W-1:0]     len_q, len_next;
  logic [CFG_W-1:0]     data_q;
  logic                 len_en, data_en, len_bad, last_frame, wr;

  assign hist_d     = {hist_q[2:0], DIN};
  assign len_en     = DIN_VALID && (state_q == ST_LEN);
  assign data_en    = DIN_VALID && (state_q == ST_DATA);
  assign len_next   = {len_q[LEN_W-2:0], DIN};
  assign len_bad    = (len_next == '0) || (len_next > MAX_LEN);
  // Frame counter is one bit wider than the address so a full array compares cleanly
  assign last_frame = (LEN_W'(frame_cnt_q) == (len_q - LEN_ONE));

  clb_cfg_shreg #(.DATA_W(LEN_W)) u_len_shreg (
    .clk (K),
    .en  (len_en),
    .din (DIN),
    .q   (len_q)
  );

  clb_cfg_shreg #(.DATA_W(CFG_W)) u_data_shreg (
    .clk (K),
    .en  (data_en),
    .din (DIN),
    .q   (data_q)
  );

  always_comb begin
    state_d = state_q;
    wr      = 1'b0;
    if (DIN_VALID) begin
      case (state_q)
        ST_IDLE:  if (hist_d == PREAMBLE) state_d = ST_LEN;
        ST_LEN:   if (bit_cnt_q == LEN_LAST) state_d = len_bad ? ST_ERR : ST_START;
        ST_START: if (!DIN) state_d = ST_DATA;
        ST_DATA:  if (bit_cnt_q == DATA_LAST) state_d = ST_STOP;
        ST_STOP: begin
          if (DIN) begin
            wr      = 1'b1;
            state_d = last_frame ? ST_DONE : ST_START;
          end else begin
            state_d = ST_ERR;
          end
        end
        default:  state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge K) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      hist_q      <= 4'b1111;
      bit_cnt_q   <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (DIN_VALID && (state_q == ST_IDLE)) hist_q <= hist_d;
      if (len_en || data_en) bit_cnt_q <= (state_d == state_q) ? bit_cnt_q + CNT_ONE : '0;
      if (wr) frame_cnt_q <= frame_cnt_q + FRM_ONE;
    end
  end

  // Output register stage: strobe, word and address land together
  always_ff @(posedge K) begin
    if (RST) begin
      CFG_DATA <= '0;
      CFG_ADDR <= '0;
      CFG_WE   <= 1'b0;
      DONE     <= 1'b0;
      ERR      <= 1'b0;
    end else begin
      CFG_WE <= wr;
      if (wr) begin
        CFG_DATA <= data_q;
        CFG_ADDR <= frame_cnt_q[ADDR_W-1:0];
      end
      DONE <= (state_d == ST_DONE);
      ERR  <= (state_d == ST_ERR);
    end
  end

endmodule

// File: tb/tb_clb_cfg_loader.sv
// Scoreboard bench for clb_cfg_loader: serial stimulus tasks push expected
// writes; a monitor pops and compares on every CFG_WE.
`timescale 1ns/1ps
module tb_clb_cfg_loader;
  import clb_cfg_pkg::*;

  localparam int NUM_CLB = 64;
  localparam int ADDR_W  = 6;

  logic              K = 1'b0;
  logic              RST = 1'b0;
  logic              DIN = 1'b1;
  logic              DIN_VALID = 1'b0;
  logic [CFG_W-1:0]  CFG_DATA;
  logic [ADDR_W-1:0] CFG_ADDR;
  logic              CFG_WE, DONE, ERR;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int we_cnt = 0;

  typedef struct packed {
    logic              last;
    logic [ADDR_W-1:0] addr;
    logic [CFG_W-1:0]  data;
  } exp_t;

  exp_t exp_q[$];
  int   we_cyc_q[$];
  exp_t mon_e;

  always #5 K = ~K;

  clb_cfg_loader #(.NUM_CLB(NUM_CLB), .ADDR_W(ADDR_W)) dut (
    .K         (K),
    .RST       (RST),
    .DIN       (DIN),
    .DIN_VALID (DIN_VALID),
    .CFG_DATA  (CFG_DATA),
    .CFG_ADDR  (CFG_ADDR),
    .CFG_WE    (CFG_WE),
    .DONE      (DONE),
    .ERR       (ERR)
  );

  // Monitor: every strobe must match the head of the scoreboard
  always @(posedge K) begin
    #1;
    cyc++;
    if (CFG_WE === 1'b1) begin
      we_cnt++;
      we_cyc_q.push_back(cyc);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_we addr=%0d data=%h", CFG_ADDR, CFG_DATA);
      end else begin
        mon_e = exp_q.pop_front();
        if (CFG_ADDR !== mon_e.addr || CFG_DATA !== mon_e.data) begin
          errors++;
          $display("FAIL write addr/data got %0d/%h expected %0d/%h",
                   CFG_ADDR, CFG_DATA, mon_e.addr, mon_e.data);
        end
        checks++;
        if (DONE !== mon_e.last) begin
          errors++;
          $display("FAIL done_at_we addr=%0d got %b expected %b", CFG_ADDR, DONE, mon_e.last);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  task automatic send_bit(input logic b, input int gap_max);
    int g;
    g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
    repeat (g) begin
      @(negedge K);
      DIN_VALID = 1'b0;
      DIN       = 1'($urandom_range(0, 1));
    end
    @(negedge K);
    DIN       = b;
    DIN_VALID = 1'b1;
  endtask

  task automatic go_idle(input int n);
    repeat (n) begin
      @(negedge K);
      DIN_VALID = 1'b0;
      DIN       = 1'b1;
    end
  endtask

  task automatic send_hdr(input logic [15:0] n, input int gap_max, output int pre_cyc);
    logic [3:0] pre;
    pre = 4'b0010;
    for (int i = 0; i < 8; i++) send_bit(1'b1, gap_max);
    send_bit(pre[3], gap_max);
    pre_cyc = cyc;
    for (int i = 2; i >= 0; i--) send_bit(pre[i], gap_max);
    for (int i = 15; i >= 0; i--) send_bit(n[i], gap_max);
  endtask

  task automatic send_frame(input logic [CFG_W-1:0] w, input logic stop,
                            input logic [ADDR_W-1:0] addr, input logic last, input int gap_max);
    send_bit(1'b0, gap_max);
    for (int i = CFG_W - 1; i >= 0; i--) send_bit(w[i], gap_max);
    if (stop) exp_q.push_back({last, addr, w});
    send_bit(stop, gap_max);
  endtask

  task automatic do_reset(input int n);
    @(negedge K);
    RST       = 1'b1;
    DIN_VALID = 1'b0;
    DIN       = 1'b1;
    repeat (n) @(negedge K);
    RST = 1'b0;
    exp_q.delete();
    we_cyc_q.delete();
    we_cnt = 0;
  endtask

  function automatic logic [CFG_W-1:0] rand_word();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[CFG_W-1:0];
  endfunction

  task automatic test_reset();
    int p;
    do_reset(2);
    send_hdr(16'd2, 0, p);
    send_frame(rand_word(), 1'b1, 6'd0, 1'b0, 0);
    send_bit(1'b0, 0);
    for (int i = 0; i < 10; i++) send_bit(1'($urandom_range(0, 1)), 0);
    @(negedge K);
    RST       = 1'b1;
    DIN_VALID = 1'b1;
    DIN       = 1'b0;
    repeat (3) @(negedge K);
    checks++; if (CFG_DATA !== '0) begin errors++; $display("FAIL rst_cfg_data got %h expected 0", CFG_DATA); end
    checks++; if (CFG_ADDR !== '0) begin errors++; $display("FAIL rst_cfg_addr got %0d expected 0", CFG_ADDR); end
    checks++; if (CFG_WE !== 1'b0) begin errors++; $display("FAIL rst_cfg_we got %b expected 0", CFG_WE); end
    checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL rst_done got %b expected 0", DONE); end
    checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL rst_err got %b expected 0", ERR); end
    checks++; if (dut.state_q !== ST_IDLE) begin errors++; $display("FAIL rst_state got %0d expected %0d", dut.state_q, ST_IDLE); end
    checks++; if (dut.hist_q !== 4'b1111) begin errors++; $display("FAIL rst_hist got %b expected 1111", dut.hist_q); end
    RST       = 1'b0;
    DIN_VALID = 1'b0;
    exp_q.delete();
    we_cyc_q.delete();
    we_cnt = 0;
    send_hdr(16'd1, 0, p);
    send_frame(rand_word(), 1'b1, 6'd0, 1'b1, 0);
    go_idle(3);
    checks++; if (we_cnt != 1) begin errors++; $display("FAIL rst_reload_we_cnt got %0d expected 1", we_cnt); end
    checks++; if (DONE !== 1'b1) begin errors++; $display("FAIL rst_reload_done got %b expected 1", DONE); end
  endtask

  task automatic test_single();
    int p;
    logic [CFG_W-1:0] w;
    do_reset(2);
    w = {16'h0116, 2'b00, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00, 6'b000111, 2'b00, 1'b0};
    send_hdr(16'd1, 0, p);
    send_frame(w, 1'b1, 6'd0, 1'b1, 0);
    go_idle(3);
    checks++; if (we_cnt != 1) begin errors++; $display("FAIL single_we_cnt got %0d expected 1", we_cnt); end
    checks++;
    if (we_cyc_q.size() != 1 || we_cyc_q[0] - p != 59) begin
      errors++;
      $display("FAIL single_latency got %0d expected 59", (we_cyc_q.size() > 0) ? we_cyc_q[0] - p : -1);
    end
    checks++; if (CFG_DATA[36:21] !== 16'h0116) begin errors++; $display("FAIL single_mem got %h expected 0116", CFG_DATA[36:21]); end
    checks++; if (CFG_DATA[18:13] !== 6'b101010) begin errors++; $display("FAIL single_mux234 got %b expected 101010", CFG_DATA[18:13]); end
    checks++; if (CFG_DATA[8:3] !== 6'b000111) begin errors++; $display("FAIL single_o2m got %b expected 000111", CFG_DATA[8:3]); end
    checks++;
    if ({CFG_DATA[20:19], CFG_DATA[12:9], CFG_DATA[2:0]} !== 9'd0) begin
      errors++;
      $display("FAIL single_zero_fields got %b expected 0", {CFG_DATA[20:19], CFG_DATA[12:9], CFG_DATA[2:0]});
    end
    checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL single_err got %b expected 0", ERR); end
  endtask

  task automatic test_full_load();
    int p;
    do_reset(2);
    send_hdr(16'd64, 2, p);
    for (int i = 0; i < 64; i++)
      send_frame(rand_word(), 1'b1, ADDR_W'(i), (i == 63), 2);
    go_idle(5);
    checks++; if (we_cnt != 64) begin errors++; $display("FAIL full_we_cnt got %0d expected 64", we_cnt); end
    checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL full_err got %b expected 0", ERR); end
    checks++; if (DONE !== 1'b1) begin errors++; $display("FAIL full_done got %b expected 1", DONE); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL full_pending got %0d expected 0", exp_q.size()); end
  endtask

  task automatic test_bad_stop();
    int p;
    do_reset(2);
    send_hdr(16'd4, 1, p);
    send_frame(rand_word(), 1'b1, 6'd0, 1'b0, 1);
    send_frame(rand_word(), 1'b1, 6'd1, 1'b0, 1);
    send_frame(rand_word(), 1'b0, 6'd2, 1'b0, 0);
    checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL badstop_err_early got %b expected 0", ERR); end
    @(posedge K);
    #2;
    checks++; if (ERR !== 1'b1) begin errors++; $display("FAIL badstop_err got %b expected 1", ERR); end
    for (int i = 0; i < 80; i++) send_bit(1'($urandom_range(0, 1)), 0);
    go_idle(3);
    checks++; if (we_cnt != 2) begin errors++; $display("FAIL badstop_we_cnt got %0d expected 2", we_cnt); end
    checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL badstop_done got %b expected 0", DONE); end
    checks++; if (ERR !== 1'b1) begin errors++; $display("FAIL badstop_err_sticky got %b expected 1", ERR); end
  endtask

  task automatic test_bad_len();
    int p;
    logic [15:0] lens [2];
    lens[0] = 16'd0;
    lens[1] = 16'd65;
    for (int k = 0; k < 2; k++) begin
      do_reset(2);
      send_hdr(lens[k], 0, p);
      checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL badlen%0d_err_early got %b expected 0", lens[k], ERR); end
      @(posedge K);
      #2;
      checks++; if (ERR !== 1'b1) begin errors++; $display("FAIL badlen%0d_err got %b expected 1", lens[k], ERR); end
      for (int i = 0; i < 50; i++) send_bit(1'($urandom_range(0, 1)), 0);
      go_idle(3);
      checks++; if (we_cnt != 0) begin errors++; $display("FAIL badlen%0d_we_cnt got %0d expected 0", lens[k], we_cnt); end
      checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL badlen%0d_done got %b expected 0", lens[k], DONE); end
    end
  endtask

  task automatic test_idle_fill();
    int p;
    do_reset(2);
    send_hdr(16'd2, 0, p);
    send_frame(rand_word(), 1'b1, 6'd0, 1'b0, 0);
    for (int i = 0; i < 5; i++) send_bit(1'b1, 0);
    send_frame(rand_word(), 1'b1, 6'd1, 1'b1, 0);
    go_idle(3);
    checks++; if (we_cnt != 2) begin errors++; $display("FAIL fill_we_cnt got %0d expected 2", we_cnt); end
    checks++;
    if (we_cyc_q.size() != 2 || we_cyc_q[1] - we_cyc_q[0] != 44) begin
      errors++;
      $display("FAIL fill_spacing got %0d expected 44",
               (we_cyc_q.size() == 2) ? we_cyc_q[1] - we_cyc_q[0] : -1);
    end
    checks++; if (DONE !== 1'b1 || ERR !== 1'b0) begin errors++; $display("FAIL fill_status got done=%b err=%b expected done=1 err=0", DONE, ERR); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_full_load();
    test_bad_stop();
    test_bad_len();
    test_idle_fill();
    go_idle(5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
